// File: rtl/ctrl_unit_fsm_pkg.sv
// Shared constants for the sequencer, the X/Y/Z register blocks and the ULA:
// register control codes, ULA selects, opcodes and sequencer state encoding.
package ctrl_unit_fsm_pkg;

   localparam int CODE_W_DEF = 4;

   localparam logic [3:0] CODE_CLEAR  = 4'd0;
   localparam logic [3:0] CODE_LOAD   = 4'd1;
   localparam logic [3:0] CODE_HOLD   = 4'd2;
   localparam logic [3:0] CODE_SHIFTR = 4'd3;

   localparam logic [1:0] ULA_ADD   = 2'd0;
   localparam logic [1:0] ULA_SUB   = 2'd1;
   localparam logic [1:0] ULA_PASSX = 2'd2;
   localparam logic [1:0] ULA_PASSY = 2'd3;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_CLR  = 4'h1;
   localparam logic [3:0] OP_LDX  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_SHRY = 4'h5;
   localparam logic [3:0] OP_MOVZ = 4'h6;
   localparam logic [3:0] OP_SHRN = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   function automatic logic [3:0] opcode_of(input logic [7:0] word);
      return word[7:4];
   endfunction

endpackage

// File: rtl/ctrl_unit_fsm_decode.sv
// Combinational instruction decode: opcode/immediate to register codes, ULA select, immediate.
// Undefined opcodes and SHRN 0 decode to an all-HOLD bundle.
module ctrl_decode
   import ctrl_unit_fsm_pkg::*;
#(
   parameter int CODE_W = 4
) (
   input  logic [7:0]        instr_i,
   output logic [CODE_W-1:0] tx_o,
   output logic [CODE_W-1:0] ty_o,
   output logic [CODE_W-1:0] tz_o,
   output logic [1:0]        ula_op_o,
   output logic [3:0]        imm_o
);

   logic [3:0] opcode;
   logic [3:0] field;

   assign opcode = opcode_of(instr_i);
   assign field  = instr_i[3:0];

   always_comb begin
      tx_o     = CODE_W'(CODE_HOLD);
      ty_o     = CODE_W'(CODE_HOLD);
      tz_o     = CODE_W'(CODE_HOLD);
      ula_op_o = ULA_ADD;
      imm_o    = 4'd0;
      case (opcode)
         OP_CLR: begin
            tx_o = CODE_W'(CODE_CLEAR);
            ty_o = CODE_W'(CODE_CLEAR);
            tz_o = CODE_W'(CODE_CLEAR);
         end
         OP_LDX: begin
            tx_o  = CODE_W'(CODE_LOAD);
            imm_o = field;
         end
         OP_ADD: begin
            ula_op_o = ULA_ADD;
            ty_o     = CODE_W'(CODE_LOAD);
         end
         OP_SUB: begin
            ula_op_o = ULA_SUB;
            ty_o     = CODE_W'(CODE_LOAD);
         end
         OP_SHRY: ty_o = CODE_W'(CODE_SHIFTR);
         OP_MOVZ: begin
            ula_op_o = ULA_PASSY;
            tz_o     = CODE_W'(CODE_LOAD);
         end
         // The first of the n shifts happens in EXEC; a zero count is a NOP.
         OP_SHRN: begin
            if (field != 4'd0) ty_o = CODE_W'(CODE_SHIFTR);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrl_unit_fsm.sv
// Instruction sequencer for the X/Y/Z datapath and ULA: FETCH/EXEC per instruction,
// SHIFT state for multi-cycle SHRN, all outputs registered.
module ctrl_unit_fsm
   import ctrl_unit_fsm_pkg::*;
#(
   parameter int PC_W   = 4,
   parameter int CODE_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        instr,
   output logic [PC_W-1:0]   pc,
   output logic [CODE_W-1:0] tx,
   output logic [CODE_W-1:0] ty,
   output logic [CODE_W-1:0] tz,
   output logic [1:0]        ula_op,
   output logic [3:0]        imm,
   output logic              busy,
   output logic              halted
);

   state_e              state_q;
   logic [PC_W-1:0]     pc_q;
   logic [PC_W-1:0]     pc_d;
   logic [7:0]          ir_q;
   logic [3:0]          cnt_q;
   logic [3:0]          cnt_d;
   logic [CODE_W-1:0]   tx_q;
   logic [CODE_W-1:0]   ty_q;
   logic [CODE_W-1:0]   tz_q;
   logic [1:0]          ula_op_q;
   logic [3:0]          imm_q;
   logic                busy_q;
   logic                halted_q;

   logic [CODE_W-1:0]   dec_tx;
   logic [CODE_W-1:0]   dec_ty;
   logic [CODE_W-1:0]   dec_tz;
   logic [1:0]          dec_ula_op;
   logic [3:0]          dec_imm;

   // Decode straight from the memory word so EXEC codes are registered on entry.
   ctrl_decode #(
      .CODE_W (CODE_W)
   ) u_decode (
      .instr_i  (instr),
      .tx_o     (dec_tx),
      .ty_o     (dec_ty),
      .tz_o     (dec_tz),
      .ula_op_o (dec_ula_op),
      .imm_o    (dec_imm)
   );

   assign pc_d  = pc_q + PC_W'(1);
   assign cnt_d = cnt_q - 4'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         cnt_q    <= '0;
         tx_q     <= CODE_W'(CODE_HOLD);
         ty_q     <= CODE_W'(CODE_HOLD);
         tz_q     <= CODE_W'(CODE_HOLD);
         ula_op_q <= ULA_ADD;
         imm_q    <= '0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         tx_q     <= CODE_W'(CODE_HOLD);
         ty_q     <= CODE_W'(CODE_HOLD);
         tz_q     <= CODE_W'(CODE_HOLD);
         ula_op_q <= ULA_ADD;
         imm_q    <= '0;
         case (state_q)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  state_q  <= ST_FETCH;
                  pc_q     <= '0;
                  busy_q   <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            ST_FETCH: begin
               ir_q     <= instr;
               state_q  <= ST_EXEC;
               tx_q     <= dec_tx;
               ty_q     <= dec_ty;
               tz_q     <= dec_tz;
               ula_op_q <= dec_ula_op;
               imm_q    <= dec_imm;
            end
            ST_EXEC: begin
               if (opcode_of(ir_q) == OP_HALT) begin
                  state_q  <= ST_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else if (opcode_of(ir_q) == OP_SHRN && ir_q[3:0] > 4'd1) begin
                  // cnt_q holds the number of SHIFT cycles still to run, this one included.
                  state_q <= ST_SHIFT;
                  cnt_q   <= ir_q[3:0] - 4'd1;
                  ty_q    <= CODE_W'(CODE_SHIFTR);
               end else begin
                  state_q <= ST_FETCH;
                  pc_q    <= pc_d;
               end
            end
            ST_SHIFT: begin
               cnt_q <= cnt_d;
               if (cnt_d != 4'd0) begin
                  ty_q <= CODE_W'(CODE_SHIFTR);
               end else begin
                  state_q <= ST_FETCH;
                  pc_q    <= pc_d;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               busy_q   <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc     = pc_q;
   assign tx     = tx_q;
   assign ty     = ty_q;
   assign tz     = tz_q;
   assign ula_op = ula_op_q;
   assign imm    = imm_q;
   assign busy   = busy_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// Directed bench for ctrl_unit_fsm: expected per-cycle output snapshots are queued
// when stimulus is applied and compared one per clock, 1 time unit after the edge.
module tb_ctrl_unit_fsm;

   localparam int CL = 0;
   localparam int LD = 1;
   localparam int H  = 2;
   localparam int SR = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] instr;
   logic [3:0] pc;
   logic [3:0] tx;
   logic [3:0] ty;
   logic [3:0] tz;
   logic [1:0] ula_op;
   logic [3:0] imm;
   logic       busy;
   logic       halted;

   logic [7:0]  prog [16];
   logic [23:0] obs_now;
   logic [23:0] exp_q [$];
   string       tag_q [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;

   always #5 clock = ~clock;

   assign instr   = prog[pc];
   assign obs_now = {pc, tx, ty, tz, ula_op, imm, busy, halted};

   ctrl_unit_fsm #(
      .PC_W   (4),
      .CODE_W (4)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .instr  (instr),
      .pc     (pc),
      .tx     (tx),
      .ty     (ty),
      .tz     (tz),
      .ula_op (ula_op),
      .imm    (imm),
      .busy   (busy),
      .halted (halted)
   );

   function automatic logic [23:0] snap(int p, int x, int y, int z, int op, int im, int b, int hl);
      return {4'(p), 4'(x), 4'(y), 4'(z), 2'(op), 4'(im), 1'(b), 1'(hl)};
   endfunction

   task automatic expect_out(string t, logic [23:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic check(string t, logic [23:0] obs, logic [23:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed {pc,tx,ty,tz,op,imm,busy,halted}=%h required %h", t, obs, exp);
      end
   endtask

   task automatic tick();
      string       t;
      logic [23:0] e;
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         check(t, obs_now, e);
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         tick();
         guard++;
      end
   endtask

   task automatic load_prog(logic [7:0] w0, logic [7:0] w1, logic [7:0] w2, logic [7:0] w3);
      foreach (prog[i]) prog[i] = 8'h00;
      prog[0] = w0;
      prog[1] = w1;
      prog[2] = w2;
      prog[3] = w3;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      load_prog(8'h00, 8'h00, 8'h00, 8'h00);

      // Reset state
      expect_out("reset_idle", snap(0, H, H, H, 0, 0, 0, 0));
      expect_out("reset_idle2", snap(0, H, H, H, 0, 0, 0, 0));
      tick();
      tick();
      reset = 1'b0;
      expect_out("idle_no_start", snap(0, H, H, H, 0, 0, 0, 0));
      tick();

      // LDX 3 / ADD / MOVZ / HALT
      load_prog(8'h23, 8'h30, 8'h60, 8'hF0);
      expect_out("p1_fetch0", snap(0, H, H, H, 0, 0, 1, 0));
      expect_out("p1_ldx",    snap(0, LD, H, H, 0, 3, 1, 0));
      expect_out("p1_fetch1", snap(1, H, H, H, 0, 0, 1, 0));
      expect_out("p1_add",    snap(1, H, LD, H, 0, 0, 1, 0));
      expect_out("p1_fetch2", snap(2, H, H, H, 0, 0, 1, 0));
      expect_out("p1_movz",   snap(2, H, H, LD, 3, 0, 1, 0));
      expect_out("p1_fetch3", snap(3, H, H, H, 0, 0, 1, 0));
      expect_out("p1_halt_ex", snap(3, H, H, H, 0, 0, 1, 0));
      expect_out("p1_halted", snap(3, H, H, H, 0, 0, 0, 1));
      expect_out("p1_halt_stay", snap(3, H, H, H, 0, 0, 0, 1));
      start = 1'b1;
      tick();
      start = 1'b0;
      drain();

      // SHRN 3 then SHRN 0, restarted from HALT
      load_prog(8'h73, 8'h70, 8'hF0, 8'h00);
      expect_out("p2_fetch0", snap(0, H, H, H, 0, 0, 1, 0));
      expect_out("p2_shr1",   snap(0, H, SR, H, 0, 0, 1, 0));
      expect_out("p2_shr2",   snap(0, H, SR, H, 0, 0, 1, 0));
      expect_out("p2_shr3",   snap(0, H, SR, H, 0, 0, 1, 0));
      expect_out("p2_fetch1", snap(1, H, H, H, 0, 0, 1, 0));
      expect_out("p2_shrn0",  snap(1, H, H, H, 0, 0, 1, 0));
      expect_out("p2_fetch2", snap(2, H, H, H, 0, 0, 1, 0));
      expect_out("p2_halt_ex", snap(2, H, H, H, 0, 0, 1, 0));
      expect_out("p2_halted", snap(2, H, H, H, 0, 0, 0, 1));
      start = 1'b1;
      tick();
      start = 1'b0;
      drain();

      // Opcode 9 with nonzero imm, start during EXEC ignored, CLR
      load_prog(8'h9A, 8'h23, 8'h15, 8'hF0);
      expect_out("p3_fetch0", snap(0, H, H, H, 0, 0, 1, 0));
      expect_out("p3_op9",    snap(0, H, H, H, 0, 0, 1, 0));
      expect_out("p3_ign_start", snap(1, H, H, H, 0, 0, 1, 0));
      expect_out("p3_ldx",    snap(1, LD, H, H, 0, 3, 1, 0));
      expect_out("p3_fetch2", snap(2, H, H, H, 0, 0, 1, 0));
      expect_out("p3_clr",    snap(2, CL, CL, CL, 0, 0, 1, 0));
      expect_out("p3_fetch3", snap(3, H, H, H, 0, 0, 1, 0));
      expect_out("p3_halt_ex", snap(3, H, H, H, 0, 0, 1, 0));
      expect_out("p3_halted", snap(3, H, H, H, 0, 0, 0, 1));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      drain();

      // SHRN 15 interrupted by reset on its 4th shift cycle
      load_prog(8'h7F, 8'h00, 8'h00, 8'h00);
      expect_out("p4_fetch0", snap(0, H, H, H, 0, 0, 1, 0));
      expect_out("p4_shr1",   snap(0, H, SR, H, 0, 0, 1, 0));
      expect_out("p4_shr2",   snap(0, H, SR, H, 0, 0, 1, 0));
      expect_out("p4_shr3",   snap(0, H, SR, H, 0, 0, 1, 0));
      expect_out("p4_shr4",   snap(0, H, SR, H, 0, 0, 1, 0));
      start = 1'b1;
      tick();
      start = 1'b0;
      drain();
      reset = 1'b1;
      expect_out("p4_reset_idle", snap(0, H, H, H, 0, 0, 0, 0));
      tick();
      reset = 1'b0;
      expect_out("p4_restart_fetch", snap(0, H, H, H, 0, 0, 1, 0));
      expect_out("p4_restart_shr1",  snap(0, H, SR, H, 0, 0, 1, 0));
      start = 1'b1;
      tick();
      start = 1'b0;
      drain();
      reset = 1'b1;
      expect_out("p4_reset2", snap(0, H, H, H, 0, 0, 0, 0));
      tick();
      reset = 1'b0;

      // 16 NOPs: pc wraps back to 0 without halting
      load_prog(8'h00, 8'h00, 8'h00, 8'h00);
      for (int k = 0; k < 16; k++) begin
         expect_out($sformatf("wrap_fetch%0d", k), snap(k, H, H, H, 0, 0, 1, 0));
         expect_out($sformatf("wrap_exec%0d", k),  snap(k, H, H, H, 0, 0, 1, 0));
      end
      expect_out("wrap_fetch0_again", snap(0, H, H, H, 0, 0, 1, 0));
      expect_out("wrap_exec0_again",  snap(0, H, H, H, 0, 0, 1, 0));
      start = 1'b1;
      tick();
      start = 1'b0;
      drain();
      reset = 1'b1;
      expect_out("final_reset", snap(0, H, H, H, 0, 0, 0, 0));
      tick();
      reset = 1'b0;

      check("queue_empty", 24'(exp_q.size()), 24'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ctrl_unit_fsm.md
Name: ctrl_unit_fsm

Overview:
- Instruction sequencer directly upstream of the X/Y/Z datapath registers and the ULA.
- Fetches 8-bit instructions from an external program memory addressed by pc.
- Decodes them into per-register control codes tx/ty/tz (CLEAR/LOAD/HOLD/SHIFTR) plus a ULA operation select.
- Supports multi-cycle instructions: repeated right-shift of Y, driven by an internal down-counter.

Parameters:
- PC_W, 4, program counter width; program length is 2**PC_W and pc wraps.
- CODE_W, 4, width of the tx/ty/tz control codes; must match the register blocks.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle pulse; begins execution at pc=0 from IDLE or HALT
- instr  in  8  program word at address pc, combinational from memory; [7:4] opcode, [3:0] imm
- pc  out  PC_W  program address
- tx  out  CODE_W  X register control
- ty  out  CODE_W  Y register control
- tz  out  CODE_W  Z register control
- ula_op  out  2  0 ADD, 1 SUB, 2 PASSX, 3 PASSY
- imm  out  4  immediate value presented to the X load mux
- busy  out  1  high in FETCH/EXEC/SHIFT
- halted  out  1  high in HALT

Behaviour:
- Control code constants: CLEAR=0, LOAD=1, HOLD=2, SHIFTR=3.
- All outputs are registered.
- Reset values:
  - state=IDLE, pc=0
  - tx=ty=tz=HOLD (datapath contents preserved)
  - ula_op=0, imm=0, busy=0, halted=0, shift counter=0
- States:
  - IDLE: wait for start. start -> FETCH with pc=0.
  - FETCH: one cycle, codes HOLD. Latch instr into ir at the end of the cycle. Next state EXEC.
  - EXEC: drive the codes for ir for exactly one cycle. Datapath registers act on the following posedge.
  - SHIFT: ty=SHIFTR each cycle while the counter is nonzero; counter decrements each cycle.
  - HALT: halted=1, codes HOLD. start -> FETCH with pc=0. Otherwise stay.
- Opcodes; unlisted fields are HOLD:
  - 0 NOP: nothing driven.
  - 1 CLR: tx=ty=tz=CLEAR.
  - 2 LDX: tx=LOAD, imm=ir[3:0].
  - 3 ADD: ula_op=ADD, ty=LOAD.
  - 4 SUB: ula_op=SUB, ty=LOAD.
  - 5 SHRY: ty=SHIFTR.
  - 6 MOVZ: ula_op=PASSY, tz=LOAD.
  - 7 SHRN: imm n. n=0 acts as NOP. n>0: EXEC drives ty=SHIFTR, counter=n-1; if counter>0 go to SHIFT, else FETCH. Total Y shifts = n.
  - 15 HALT: go to HALT; pc unchanged.
  - 8-14: treated as NOP.
- pc increments by 1 when leaving EXEC or SHIFT for FETCH. Wraps 2**PC_W-1 -> 0 without halting.
- start outside IDLE/HALT is ignored.
- reset has priority over everything, including mid-SHIFT. Its effect is visible the cycle after the reset edge.
- Latency: every single-cycle instruction takes 2 clocks (FETCH+EXEC). SHRN n takes 1+n clocks for n>=1.

Decomposition:
- Shared package/include holds:
  - control codes CLEAR/LOAD/HOLD/SHIFTR
  - ULA op codes
  - opcode constants
  - state encoding
- The same constants are reused by the register and ULA blocks.
- One natural sub-module: ctrl_decode. Combinational map from opcode/imm to tx/ty/tz/ula_op/imm. The FSM registers its outputs.

Test Plan:
- Reset check: assert reset in any state -> next cycle state IDLE, pc=0, tx=ty=tz=2, busy=0, halted=0.
- Sequence: program {0x23 LDX 3, 0x30 ADD, 0x60 MOVZ, 0xF0 HALT}, pulse start. Required outputs:
  - cycle 2: tx=1, imm=3
  - cycle 4: ty=1, ula_op=0
  - cycle 6: tz=1, ula_op=3
  - then halted=1 with pc=3
- SHRN: instr 0x73 -> ty=3 for exactly 3 consecutive cycles, then FETCH with pc+1. Instr 0x70 -> no SHIFTR cycle.
- Wrap: program of 16 NOPs, run from start -> after 32 clocks pc returns to 0 and busy stays 1.
- Reset mid-SHIFT: during 0x7F, assert reset at the 4th shift cycle -> ty=2 next cycle, IDLE, pc=0. start then restarts at pc=0.
- Ignored start / restart: start pulsed during EXEC -> no effect. start in HALT -> FETCH at pc=0. Opcode 0x9 -> all codes HOLD.
